// File: rtl/sprite_rom_arbiter.sv
// Arbitrates one shared sprite ROM between the Pac-Man and ghost fetchers, one pixel at a time.
// Define GHOST_SPRITE_EN to enable the ghost fetch path; without it only Pac-Man is looked up.
module sprite_rom_arbiter (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        pix_start_i,
   input  logic        pac_req_i,
   input  logic [11:0] pac_addr_i,
   input  logic        ghost_req_i,
   input  logic [11:0] ghost_addr_i,
   input  logic [23:0] rom_data_i,
   output logic        rom_rd_o,
   output logic [11:0] rom_addr_o,
   output logic        is_sprite_o,
   output logic [7:0]  sprite_r_o,
   output logic [7:0]  sprite_g_o,
   output logic [7:0]  sprite_b_o,
   output logic        pix_valid_o,
   output logic        overrun_o
);

   localparam logic [23:0] TRANSPARENT = 24'hFF00FF;

   typedef enum logic [2:0] {
      IDLE, RD_PAC, WAIT_PAC, RD_GHOST, WAIT_GHOST, DONE
   } state_t;

   state_t      state_q;
   logic        pac_req_q;
   logic [11:0] pac_addr_q;
   logic        rom_rd_q;
   logic [11:0] rom_addr_q;
   logic        is_sprite_q;
   logic [7:0]  r_q, g_q, b_q;
   logic        pix_valid_q;
   logic        overrun_q;
   logic        opaque_d;

   assign opaque_d = (rom_data_i != TRANSPARENT);

`ifdef GHOST_SPRITE_EN
   logic        ghost_req_q;
   logic [11:0] ghost_addr_q;
`else
   logic        ghost_unused;
   assign ghost_unused = ^{ghost_req_i, ghost_addr_i};
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         pac_req_q   <= 1'b0;
         pac_addr_q  <= '0;
         rom_rd_q    <= 1'b0;
         rom_addr_q  <= '0;
         is_sprite_q <= 1'b0;
         r_q         <= '0;
         g_q         <= '0;
         b_q         <= '0;
         pix_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef GHOST_SPRITE_EN
         ghost_req_q  <= 1'b0;
         ghost_addr_q <= '0;
`endif
      end else begin
         // Strobes are single-cycle: raised only on the transition that needs them.
         rom_rd_q    <= 1'b0;
         rom_addr_q  <= '0;
         pix_valid_q <= 1'b0;
         if (pix_start_i && state_q != IDLE)
            overrun_q <= 1'b1;

         case (state_q)
            IDLE: begin
               if (pix_start_i) begin
                  pac_req_q  <= pac_req_i;
                  pac_addr_q <= pac_addr_i;
`ifdef GHOST_SPRITE_EN
                  ghost_req_q  <= ghost_req_i;
                  ghost_addr_q <= ghost_addr_i;
`endif
                  if (pac_req_i) begin
                     state_q    <= RD_PAC;
                     rom_rd_q   <= 1'b1;
                     rom_addr_q <= pac_addr_i;
                  end
`ifdef GHOST_SPRITE_EN
                  else if (ghost_req_i) begin
                     state_q    <= RD_GHOST;
                     rom_rd_q   <= 1'b1;
                     rom_addr_q <= ghost_addr_i;
                  end
`endif
                  else begin
                     // Empty pixel still spends one cycle in WAIT_PAC so it resolves in two cycles.
                     state_q <= WAIT_PAC;
                  end
               end
            end
            RD_PAC: state_q <= WAIT_PAC;
            WAIT_PAC: begin
               if (pac_req_q && opaque_d) begin
                  {r_q, g_q, b_q} <= rom_data_i;
                  is_sprite_q     <= 1'b1;
                  pix_valid_q     <= 1'b1;
                  state_q         <= DONE;
               end
`ifdef GHOST_SPRITE_EN
               else if (ghost_req_q) begin
                  state_q    <= RD_GHOST;
                  rom_rd_q   <= 1'b1;
                  rom_addr_q <= ghost_addr_q;
               end
`endif
               else begin
                  is_sprite_q <= 1'b0;
                  pix_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
`ifdef GHOST_SPRITE_EN
            RD_GHOST: state_q <= WAIT_GHOST;
            WAIT_GHOST: begin
               if (opaque_d)
                  {r_q, g_q, b_q} <= rom_data_i;
               is_sprite_q <= opaque_d;
               pix_valid_q <= 1'b1;
               state_q     <= DONE;
            end
`endif
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rom_rd_o    = rom_rd_q;
   assign rom_addr_o  = rom_addr_q;
   assign is_sprite_o = is_sprite_q;
   assign sprite_r_o  = r_q;
   assign sprite_g_o  = g_q;
   assign sprite_b_o  = b_q;
   assign pix_valid_o = pix_valid_q;
   assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: ROM image responder, priority/latency reference model, directed and random fetches.
module tb_sprite_rom_arbiter;

   localparam logic [23:0] KEY = 24'hFF00FF;
`ifdef GHOST_SPRITE_EN
   localparam bit GHOST_EN = 1'b1;
`else
   localparam bit GHOST_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, pix_start, pac_req, ghost_req;
   logic [11:0] pac_addr, ghost_addr;
   logic [23:0] rom_data;
   logic        rom_rd, is_sprite, pix_valid, overrun;
   logic [11:0] rom_addr;
   logic [7:0]  spr_r, spr_g, spr_b;

   always #5 clk = ~clk;

   sprite_rom_arbiter dut (
      .clk_i(clk), .reset_i(reset), .pix_start_i(pix_start),
      .pac_req_i(pac_req), .pac_addr_i(pac_addr),
      .ghost_req_i(ghost_req), .ghost_addr_i(ghost_addr),
      .rom_data_i(rom_data), .rom_rd_o(rom_rd), .rom_addr_o(rom_addr),
      .is_sprite_o(is_sprite), .sprite_r_o(spr_r), .sprite_g_o(spr_g), .sprite_b_o(spr_b),
      .pix_valid_o(pix_valid), .overrun_o(overrun)
   );

   // ROM image: data appears the cycle after a read; junk otherwise.
   logic [23:0] rom_mem [4096];
   always @(posedge clk) rom_data <= rom_rd ? rom_mem[rom_addr] : 24'($urandom);

   int n_checks = 0;
   int n_fail   = 0;
   logic       exp_is = 1'b0;
   logic [7:0] exp_r = 8'h0, exp_g = 8'h0, exp_b = 8'h0;
   logic       exp_ovr = 1'b0;

   task automatic scramble_inputs();
      pac_req    = 1'($urandom);
      ghost_req  = 1'($urandom);
      pac_addr   = 12'($urandom);
      ghost_addr = 12'($urandom);
   endtask

   // One pixel fetch; dup > 0 re-pulses pix_start during that cycle of the fetch.
   task automatic run_fetch(input string name, input logic pr, input logic [11:0] pa,
                            input logic gr, input logic [11:0] ga, input int dup);
      logic [11:0] exp_addr[$];
      int          rd_cyc[$];
      logic [11:0] rd_addr[$];
      logic        hit;
      logic [23:0] hit_data;
      int          exp_lat, pv_cnt, pv_cyc;
      hit = 1'b0; hit_data = '0; pv_cnt = 0; pv_cyc = -1;
      // Reference: Pac-Man first, ghost only if enabled and nothing opaque yet; two cycles per read.
      if (pr) begin
         exp_addr.push_back(pa);
         if (rom_mem[pa] != KEY) begin hit = 1'b1; hit_data = rom_mem[pa]; end
      end
      if (!hit && gr && GHOST_EN) begin
         exp_addr.push_back(ga);
         if (rom_mem[ga] != KEY) begin hit = 1'b1; hit_data = rom_mem[ga]; end
      end
      exp_lat = (exp_addr.size() == 0) ? 2 : 2 * exp_addr.size() + 1;

      pac_req = pr; pac_addr = pa; ghost_req = gr; ghost_addr = ga; pix_start = 1'b1;
      for (int c = 1; c <= exp_lat + 1; c++) begin
         @(negedge clk);
         scramble_inputs();
         if (rom_rd) begin
            rd_cyc.push_back(c); rd_addr.push_back(rom_addr);
         end else begin
            n_checks++;
            if (rom_addr !== 12'h000) begin
               n_fail++; $display("FAIL %s idle_addr cyc%0d: got %h want 000", name, c, rom_addr);
            end
         end
         if (pix_valid) begin pv_cnt++; pv_cyc = c; end
         if (c < exp_lat) begin
            n_checks++;
            if ({is_sprite, spr_r, spr_g, spr_b} !== {exp_is, exp_r, exp_g, exp_b}) begin
               n_fail++;
               $display("FAIL %s held cyc%0d: got %b/%h%h%h want %b/%h%h%h", name, c,
                        is_sprite, spr_r, spr_g, spr_b, exp_is, exp_r, exp_g, exp_b);
            end
         end
         pix_start = (c == dup && c <= exp_lat);
         if (pix_start) exp_ovr = 1'b1;
      end
      pix_start = 1'b0;

      if (hit) {exp_r, exp_g, exp_b} = hit_data;
      exp_is = hit;

      n_checks++;
      if (rd_addr.size() != exp_addr.size()) begin
         n_fail++; $display("FAIL %s read_count: got %0d want %0d", name, rd_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size(); i++) begin
         if (i < rd_addr.size()) begin
            n_checks++;
            if (rd_addr[i] !== exp_addr[i] || rd_cyc[i] != 2 * i + 1) begin
               n_fail++;
               $display("FAIL %s read%0d: got %h@cyc%0d want %h@cyc%0d", name, i,
                        rd_addr[i], rd_cyc[i], exp_addr[i], 2 * i + 1);
            end
         end
      end
      n_checks++;
      if (pv_cnt != 1 || pv_cyc != exp_lat) begin
         n_fail++; $display("FAIL %s pix_valid: got %0d pulses last cyc%0d want 1 at cyc%0d",
                            name, pv_cnt, pv_cyc, exp_lat);
      end
      n_checks++;
      if ({is_sprite, spr_r, spr_g, spr_b} !== {exp_is, exp_r, exp_g, exp_b}) begin
         n_fail++; $display("FAIL %s result: got %b/%h%h%h want %b/%h%h%h", name,
                            is_sprite, spr_r, spr_g, spr_b, exp_is, exp_r, exp_g, exp_b);
      end
      n_checks++;
      if (overrun !== exp_ovr) begin
         n_fail++; $display("FAIL %s overrun: got %b want %b", name, overrun, exp_ovr);
      end
   endtask

   task automatic check_all_zero(input string name);
      n_checks++;
      if ({rom_rd, rom_addr, is_sprite, spr_r, spr_g, spr_b, pix_valid, overrun} !== '0) begin
         n_fail++;
         $display("FAIL %s: got rd=%b addr=%h is=%b rgb=%h%h%h pv=%b ovr=%b want all 0", name,
                  rom_rd, rom_addr, is_sprite, spr_r, spr_g, spr_b, pix_valid, overrun);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; pix_start = 1'b0; scramble_inputs();
      repeat (2) @(negedge clk);
      check_all_zero("reset_state");
      reset = 1'b0;
      exp_is = 1'b0; {exp_r, exp_g, exp_b} = '0; exp_ovr = 1'b0;
   endtask

   task automatic test_directed();
      rom_mem[12'h010] = 24'hFFFF00;
      rom_mem[12'h011] = KEY;
      rom_mem[12'h200] = 24'hFF0000;
      rom_mem[12'h201] = KEY;
      run_fetch("pac_opaque", 1'b1, 12'h010, 1'b0, 12'h000, 0);
      run_fetch("none_hold", 1'b0, 12'h010, 1'b0, 12'h200, 0);
      run_fetch("pac_trans_ghost", 1'b1, 12'h011, 1'b1, 12'h200, 0);
      run_fetch("ghost_only", 1'b0, 12'h000, 1'b1, 12'h200, 0);
      run_fetch("both_trans", 1'b1, 12'h011, 1'b1, 12'h201, 0);
      run_fetch("pac_over_ghost", 1'b1, 12'h010, 1'b1, 12'h200, 0);
   endtask

   task automatic test_overrun();
      run_fetch("overrun_fetch", 1'b1, 12'h010, 1'b0, 12'h000, 2);
      run_fetch("overrun_sticky", 1'b1, 12'h011, 1'b1, 12'h200, 0);
      run_fetch("overrun_in_done", 1'b0, 12'h000, 1'b1, 12'h200, GHOST_EN ? 3 : 2);
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         logic [11:0] pa, ga;
         pa = 12'($urandom); ga = 12'($urandom);
         run_fetch("random", 1'($urandom), pa, 1'($urandom), ga, ($urandom_range(0, 5) == 0) ? 1 : 0);
      end
   endtask

   task automatic test_reset_midfetch();
      int bad;
      rom_mem[12'h010] = KEY;
      rom_mem[12'h200] = 24'hFF0000;
      pac_req = 1'b1; pac_addr = 12'h010; ghost_req = 1'b1; ghost_addr = 12'h200; pix_start = 1'b1;
      @(negedge clk);
      pix_start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_all_zero("reset_midfetch");
      reset = 1'b0;
      exp_is = 1'b0; {exp_r, exp_g, exp_b} = '0; exp_ovr = 1'b0;
      bad = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (pix_valid || rom_rd) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++; $display("FAIL reset_abort: got %0d active cycles want 0", bad);
      end
      // Reset coincident with pix_start: request must not be accepted.
      reset = 1'b1; pix_start = 1'b1; pac_req = 1'b1; pac_addr = 12'h200;
      @(negedge clk);
      reset = 1'b0; pix_start = 1'b0;
      bad = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (pix_valid || rom_rd || overrun) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++; $display("FAIL reset_dominates: got %0d active cycles want 0", bad);
      end
      run_fetch("after_reset", 1'b1, 12'h200, 1'b0, 12'h000, 0);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++)
         rom_mem[i] = ($urandom_range(0, 2) == 0) ? KEY : 24'($urandom);
      reset = 1'b1; pix_start = 1'b0;
      pac_req = 1'b0; ghost_req = 1'b0; pac_addr = '0; ghost_addr = '0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_overrun();
      test_random();
      test_reset_midfetch();
      test_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
